// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle control unit and the RV64 datapath blocks
// (MemoriaInstrucao, BancoRegistradores, ULA, MemoryData).
interface unidade_controle_multiciclo_if #(
    parameter int IMEM_ADDR_W = 7
);
    logic [31:0]            instr;
    logic [63:0]            doutULA;
    logic [IMEM_ADDR_W-1:0] endr;
    logic [4:0]             Ra;
    logic [4:0]             Rb;
    logic [4:0]             Rw;
    logic                   WeR;
    logic                   WeM;
    logic                   soma_ou_subtrai;
    logic                   subtraindo;
    logic                   imediato;
    logic [63:0]            constante;
    logic [1:0]             sel_dinR;
    logic [63:0]            pc;
    logic [63:0]            pc_mais_imm;
    logic [31:0]            instr_concluidas;
    logic                   erro;

    modport master (
        input  instr, doutULA,
        output endr, Ra, Rb, Rw, WeR, WeM, soma_ou_subtrai, subtraindo, imediato,
               constante, sel_dinR, pc, pc_mais_imm, instr_concluidas, erro
    );

    modport slave (
        output instr, doutULA,
        input  endr, Ra, Rb, Rw, WeR, WeM, soma_ou_subtrai, subtraindo, imediato,
               constante, sel_dinR, pc, pc_mais_imm, instr_concluidas, erro
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit for the RV64 datapath: fetches, decodes and sequences
// ld/sd/add/sub/addi/jal/jalr/auipc, owns the PC and the retired-instruction counter.
module unidade_controle_multiciclo #(
    parameter logic [63:0] PC_RESET    = 64'h0,
    parameter int          IMEM_ADDR_W = 7
) (
    input logic clk,
    input logic reset,
    unidade_controle_multiciclo_if.master bus
);
    typedef enum logic [2:0] {
        BUSCA,
        DECODIFICA,
        EXECUTA,
        MEMORIA,
        ESCRITA,
        ERRO
    } estado_e;

    typedef enum logic [3:0] {
        OP_LD,
        OP_SD,
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_JAL,
        OP_JALR,
        OP_AUIPC,
        OP_ILEGAL
    } op_e;

    function automatic op_e decodeOp(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [6:0] funct7);
        op_e op;
        op = OP_ILEGAL;
        case (opcode)
            7'b0000011: if (funct3 == 3'b011) op = OP_LD;
            7'b0100011: if (funct3 == 3'b011) op = OP_SD;
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) op = OP_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) op = OP_SUB;
            end
            7'b0010011: if (funct3 == 3'b000) op = OP_ADDI;
            7'b1101111: op = OP_JAL;
            7'b1100111: if (funct3 == 3'b000) op = OP_JALR;
            7'b0010111: op = OP_AUIPC;
            default:    op = OP_ILEGAL;
        endcase
        return op;
    endfunction

    estado_e     stateQ, stateD;
    logic [63:0] pcQ, pcD;
    logic [31:0] irQ, irD;
    logic [31:0] countQ, countD;

    op_e         opIr;
    op_e         opNovo;
    logic [63:0] immI, immS, immJ, immU;
    logic [63:0] pcMais4;
    logic [63:0] constCmb;
    logic        weRCmb, weMCmb, somaCmb, subCmb, imedCmb;
    logic [1:0]  selCmb;

    assign opIr   = decodeOp(irQ[6:0], irQ[14:12], irQ[31:25]);
    assign opNovo = decodeOp(bus.instr[6:0], bus.instr[14:12], bus.instr[31:25]);

    assign immI    = {{52{irQ[31]}}, irQ[31:20]};
    assign immS    = {{52{irQ[31]}}, irQ[31:25], irQ[11:7]};
    assign immJ    = {{43{irQ[31]}}, irQ[31], irQ[19:12], irQ[20], irQ[30:21], 1'b0};
    assign immU    = {{32{irQ[31]}}, irQ[31:12], 12'b0};
    assign pcMais4 = pcQ + 64'd4;

    always_comb begin
        constCmb = '0;
        case (opIr)
            OP_LD, OP_ADDI, OP_JALR: constCmb = immI;
            OP_SD:                   constCmb = immS;
            OP_JAL:                  constCmb = immJ;
            OP_AUIPC:                constCmb = immU;
            default:                 constCmb = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= BUSCA;
            pcQ    <= PC_RESET;
            irQ    <= '0;
            countQ <= '0;
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            irQ    <= irD;
            countQ <= countD;
        end
    end

    // The retiring cycle of each instruction updates pc and the counter together.
    always_comb begin
        stateD  = stateQ;
        pcD     = pcQ;
        irD     = irQ;
        countD  = countQ;
        weRCmb  = 1'b0;
        weMCmb  = 1'b0;
        somaCmb = 1'b0;
        subCmb  = 1'b0;
        imedCmb = 1'b0;
        selCmb  = 2'd0;
        case (stateQ)
            BUSCA: stateD = DECODIFICA;
            DECODIFICA: begin
                irD    = bus.instr;
                stateD = (opNovo == OP_ILEGAL) ? ERRO : EXECUTA;
            end
            EXECUTA: begin
                case (opIr)
                    OP_JAL: begin
                        weRCmb = 1'b1;
                        selCmb = 2'd2;
                        pcD    = pcQ + immJ;
                        countD = countQ + 32'd1;
                        stateD = BUSCA;
                    end
                    OP_JALR: begin
                        somaCmb = 1'b1;
                        imedCmb = 1'b1;
                        weRCmb  = 1'b1;
                        selCmb  = 2'd2;
                        pcD     = bus.doutULA & ~64'h1;
                        countD  = countQ + 32'd1;
                        stateD  = BUSCA;
                    end
                    OP_AUIPC: begin
                        weRCmb = 1'b1;
                        selCmb = 2'd3;
                        pcD    = pcMais4;
                        countD = countQ + 32'd1;
                        stateD = BUSCA;
                    end
                    OP_LD, OP_SD: begin
                        somaCmb = 1'b1;
                        imedCmb = 1'b1;
                        stateD  = MEMORIA;
                    end
                    OP_ADDI: begin
                        somaCmb = 1'b1;
                        imedCmb = 1'b1;
                        stateD  = ESCRITA;
                    end
                    OP_ADD: begin
                        somaCmb = 1'b1;
                        stateD  = ESCRITA;
                    end
                    OP_SUB: begin
                        somaCmb = 1'b1;
                        subCmb  = 1'b1;
                        stateD  = ESCRITA;
                    end
                    default: stateD = ERRO;
                endcase
            end
            MEMORIA: begin
                if (opIr == OP_SD) begin
                    weMCmb = 1'b1;
                    pcD    = pcMais4;
                    countD = countQ + 32'd1;
                    stateD = BUSCA;
                end else begin
                    stateD = ESCRITA;
                end
            end
            ESCRITA: begin
                weRCmb = 1'b1;
                selCmb = (opIr == OP_LD) ? 2'd1 : 2'd0;
                pcD    = pcMais4;
                countD = countQ + 32'd1;
                stateD = BUSCA;
            end
            ERRO:    stateD = ERRO;
            default: stateD = BUSCA;
        endcase
    end

    // Write enables are masked by reset so a reset edge never commits a write.
    assign bus.WeR              = weRCmb && (irQ[11:7] != 5'd0) && !reset;
    assign bus.WeM              = weMCmb && !reset;
    assign bus.soma_ou_subtrai  = somaCmb;
    assign bus.subtraindo       = subCmb;
    assign bus.imediato         = imedCmb;
    assign bus.sel_dinR         = selCmb;
    assign bus.constante        = constCmb;
    assign bus.Ra               = irQ[19:15];
    assign bus.Rb               = irQ[24:20];
    assign bus.Rw               = irQ[11:7];
    assign bus.endr             = pcQ[IMEM_ADDR_W+1:2];
    assign bus.pc               = pcQ;
    assign bus.pc_mais_imm      = pcQ + immU;
    assign bus.instr_concluidas = countQ;
    assign bus.erro             = (stateQ == ERRO);
endmodule
